// File: rtl/core_debug_cmd_responder.sv
// Core-side debug command endpoint: halts, resumes and single-steps the core and performs
// register accesses while halted, answering every accepted command with one VALID pulse.
module core_debug_cmd_responder #(
    parameter int P_TARGET_NUM = 38,
    parameter int P_TIMEOUT    = 1023
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iDEBUG_CMD_REQ,
    output logic        oDEBUG_CMD_BUSY,
    input  logic [3:0]  iDEBUG_CMD_COMMAND,
    input  logic [11:0] iDEBUG_CMD_TARGET,
    input  logic [31:0] iDEBUG_CMD_DATA,
    output logic        oDEBUG_CMD_VALID,
    output logic        oDEBUG_CMD_ERROR,
    output logic [31:0] oDEBUG_CMD_DATA,
    output logic        oCORE_STOP_REQ,
    input  logic        iCORE_STOPPED,
    output logic        oCORE_STEP_REQ,
    input  logic        iCORE_STEP_DONE,
    output logic        oCORE_INTGO,
    output logic        oREG_REQ,
    output logic        oREG_RW,
    output logic [5:0]  oREG_ADDR,
    output logic [31:0] oREG_WDATA,
    input  logic        iREG_ACK,
    input  logic [31:0] iREG_RDATA
);

    typedef enum logic [2:0] {IDLE, STOP_WAIT, REG_WAIT, STEP_WAIT, RESP} state_t;

    localparam logic [3:0] CMD_READ  = 4'h0;
    localparam logic [3:0] CMD_WRITE = 4'h1;
    localparam logic [3:0] CMD_GO    = 4'h8;
    localparam logic [3:0] CMD_INTGO = 4'h9;
    localparam logic [3:0] CMD_STEP  = 4'hA;
    localparam logic [3:0] CMD_STOP  = 4'hF;

    localparam int          TW         = $clog2(P_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_M1 = TW'(P_TIMEOUT - 1);
    localparam logic [11:0] TARGET_NUM = 12'(P_TARGET_NUM);

    state_t        state_q, state_d;
    logic          halted_q, halted_d;
    logic          stop_req_q, stop_req_d;
    logic          step_req_q, step_req_d;
    logic          intgo_q, intgo_d;
    logic          reg_req_q, reg_req_d;
    logic          reg_rw_q, reg_rw_d;
    logic [5:0]    reg_addr_q, reg_addr_d;
    logic [31:0]   reg_wdata_q, reg_wdata_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic [31:0]   data_q, data_d;
    logic          busy_q, busy_d;
    logic [TW-1:0] timer_q, timer_d;

    logic cmd_known;
    logic target_ok;
    logic timed_out;

    assign cmd_known = (iDEBUG_CMD_COMMAND == CMD_READ) || (iDEBUG_CMD_COMMAND == CMD_WRITE) ||
                       (iDEBUG_CMD_COMMAND == CMD_GO)   || (iDEBUG_CMD_COMMAND == CMD_INTGO) ||
                       (iDEBUG_CMD_COMMAND == CMD_STEP) || (iDEBUG_CMD_COMMAND == CMD_STOP);
    // TARGET_NUM < 64, so this also rejects any nonzero TARGET[11:6]
    assign target_ok = iDEBUG_CMD_TARGET < TARGET_NUM;
    assign timed_out = timer_q == TIMEOUT_M1;

    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        stop_req_d  = stop_req_q;
        step_req_d  = 1'b0;
        intgo_d     = 1'b0;
        reg_req_d   = reg_req_q;
        reg_rw_d    = reg_rw_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        valid_d     = 1'b0;
        error_d     = 1'b0;
        data_d      = 32'h0;
        timer_d     = timer_q;

        case (state_q)
            IDLE: begin
                if (iDEBUG_CMD_REQ) begin
                    timer_d = '0;
                    state_d = RESP;
                    valid_d = 1'b1;
                    if (!cmd_known || !target_ok) begin
                        error_d = 1'b1;
                    end else begin
                        case (iDEBUG_CMD_COMMAND)
                            CMD_GO, CMD_INTGO: begin
                                stop_req_d = 1'b0;
                                halted_d   = 1'b0;
                                intgo_d    = iDEBUG_CMD_COMMAND == CMD_INTGO;
                            end
                            CMD_STOP: begin
                                if (!halted_q) begin
                                    stop_req_d = 1'b1;
                                    valid_d    = 1'b0;
                                    state_d    = STOP_WAIT;
                                end
                            end
                            CMD_READ, CMD_WRITE: begin
                                if (!halted_q) begin
                                    error_d = 1'b1;
                                end else begin
                                    valid_d     = 1'b0;
                                    state_d     = REG_WAIT;
                                    reg_req_d   = 1'b1;
                                    reg_rw_d    = iDEBUG_CMD_COMMAND == CMD_WRITE;
                                    reg_addr_d  = iDEBUG_CMD_TARGET[5:0];
                                    reg_wdata_d = (iDEBUG_CMD_COMMAND == CMD_WRITE) ? iDEBUG_CMD_DATA : 32'h0;
                                end
                            end
                            default: begin
                                if (!halted_q) begin
                                    error_d = 1'b1;
                                end else begin
                                    valid_d    = 1'b0;
                                    state_d    = STEP_WAIT;
                                    step_req_d = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            // Acknowledge takes priority over a timeout on the same edge
            STOP_WAIT: begin
                if (iCORE_STOPPED) begin
                    halted_d = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = RESP;
                end else if (timed_out) begin
                    stop_req_d = 1'b0;
                    valid_d    = 1'b1;
                    error_d    = 1'b1;
                    state_d    = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            REG_WAIT: begin
                if (iREG_ACK) begin
                    reg_req_d = 1'b0;
                    valid_d   = 1'b1;
                    data_d    = reg_rw_q ? 32'h0 : iREG_RDATA;
                    state_d   = RESP;
                end else if (timed_out) begin
                    reg_req_d = 1'b0;
                    valid_d   = 1'b1;
                    error_d   = 1'b1;
                    state_d   = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STEP_WAIT: begin
                if (iCORE_STEP_DONE) begin
                    valid_d = 1'b1;
                    state_d = RESP;
                end else if (timed_out) begin
                    valid_d = 1'b1;
                    error_d = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = state_d != IDLE;
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state_q     <= IDLE;
            halted_q    <= 1'b0;
            stop_req_q  <= 1'b0;
            step_req_q  <= 1'b0;
            intgo_q     <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_rw_q    <= 1'b0;
            reg_addr_q  <= 6'h0;
            reg_wdata_q <= 32'h0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            data_q      <= 32'h0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            stop_req_q  <= stop_req_d;
            step_req_q  <= step_req_d;
            intgo_q     <= intgo_d;
            reg_req_q   <= reg_req_d;
            reg_rw_q    <= reg_rw_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
        end
    end

    assign oDEBUG_CMD_BUSY  = busy_q;
    assign oDEBUG_CMD_VALID = valid_q;
    assign oDEBUG_CMD_ERROR = error_q;
    assign oDEBUG_CMD_DATA  = data_q;
    assign oCORE_STOP_REQ   = stop_req_q;
    assign oCORE_STEP_REQ   = step_req_q;
    assign oCORE_INTGO      = intgo_q;
    assign oREG_REQ         = reg_req_q;
    assign oREG_RW          = reg_rw_q;
    assign oREG_ADDR        = reg_addr_q;
    assign oREG_WDATA       = reg_wdata_q;

endmodule

// File: tb/tb_core_debug_cmd_responder.sv
// Directed bench for core_debug_cmd_responder: a table of immediate commands plus
// hand-written sequences for the waited commands, timeouts and reset mid-command.
module tb_core_debug_cmd_responder;

    logic        iCLOCK = 1'b0;
    logic        inRESET;
    logic        iDEBUG_CMD_REQ;
    logic        oDEBUG_CMD_BUSY;
    logic [3:0]  iDEBUG_CMD_COMMAND;
    logic [11:0] iDEBUG_CMD_TARGET;
    logic [31:0] iDEBUG_CMD_DATA;
    logic        oDEBUG_CMD_VALID;
    logic        oDEBUG_CMD_ERROR;
    logic [31:0] oDEBUG_CMD_DATA;
    logic        oCORE_STOP_REQ;
    logic        iCORE_STOPPED;
    logic        oCORE_STEP_REQ;
    logic        iCORE_STEP_DONE;
    logic        oCORE_INTGO;
    logic        oREG_REQ;
    logic        oREG_RW;
    logic [5:0]  oREG_ADDR;
    logic [31:0] oREG_WDATA;
    logic        iREG_ACK;
    logic [31:0] iREG_RDATA;

    core_debug_cmd_responder #(.P_TARGET_NUM(38), .P_TIMEOUT(8)) dut (
        .iCLOCK(iCLOCK), .inRESET(inRESET),
        .iDEBUG_CMD_REQ(iDEBUG_CMD_REQ), .oDEBUG_CMD_BUSY(oDEBUG_CMD_BUSY),
        .iDEBUG_CMD_COMMAND(iDEBUG_CMD_COMMAND), .iDEBUG_CMD_TARGET(iDEBUG_CMD_TARGET),
        .iDEBUG_CMD_DATA(iDEBUG_CMD_DATA), .oDEBUG_CMD_VALID(oDEBUG_CMD_VALID),
        .oDEBUG_CMD_ERROR(oDEBUG_CMD_ERROR), .oDEBUG_CMD_DATA(oDEBUG_CMD_DATA),
        .oCORE_STOP_REQ(oCORE_STOP_REQ), .iCORE_STOPPED(iCORE_STOPPED),
        .oCORE_STEP_REQ(oCORE_STEP_REQ), .iCORE_STEP_DONE(iCORE_STEP_DONE),
        .oCORE_INTGO(oCORE_INTGO), .oREG_REQ(oREG_REQ), .oREG_RW(oREG_RW),
        .oREG_ADDR(oREG_ADDR), .oREG_WDATA(oREG_WDATA),
        .iREG_ACK(iREG_ACK), .iREG_RDATA(iREG_RDATA)
    );

    always #5 iCLOCK = ~iCLOCK;

    typedef struct {
        string      name;
        logic       pre_halted;
        logic [3:0] cmd;
        logic [11:0] tgt;
        logic       exp_err;
        logic       exp_intgo;
        logic       exp_stop;
    } vec_t;

    vec_t vecs[12];
    int   checks   = 0;
    int   failures = 0;
    logic halted_m = 1'b0;

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!oDEBUG_CMD_VALID && n < max);
        if (!oDEBUG_CMD_VALID) begin
            checks++;
            failures++;
            $display("FAIL wait_valid actual=no_valid required=valid_within_%0d", max);
        end
    endtask

    task automatic issue(input logic [3:0] cmd, input logic [11:0] tgt, input logic [31:0] data);
        iDEBUG_CMD_REQ     = 1'b1;
        iDEBUG_CMD_COMMAND = cmd;
        iDEBUG_CMD_TARGET  = tgt;
        iDEBUG_CMD_DATA    = data;
        tick();
        iDEBUG_CMD_REQ = 1'b0;
    endtask

    task automatic do_imm(input string name, input logic [3:0] cmd, input logic [11:0] tgt,
                          input logic exp_err, input logic exp_intgo, input logic exp_stop);
        issue(cmd, tgt, 32'h0);
        check({name, "_valid"}, 32'(oDEBUG_CMD_VALID), 32'd1);
        check({name, "_error"}, 32'(oDEBUG_CMD_ERROR), 32'(exp_err));
        check({name, "_intgo"}, 32'(oCORE_INTGO), 32'(exp_intgo));
        check({name, "_stopreq"}, 32'(oCORE_STOP_REQ), 32'(exp_stop));
        check({name, "_noact"}, {30'h0, oREG_REQ, oCORE_STEP_REQ}, 32'h0);
        check({name, "_data"}, oDEBUG_CMD_DATA, 32'h0);
        check({name, "_busy"}, 32'(oDEBUG_CMD_BUSY), 32'd1);
        tick();
        check({name, "_after"}, {29'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_BUSY, oCORE_INTGO}, 32'h0);
        if (!exp_err && (cmd == 4'h8 || cmd == 4'h9)) halted_m = 1'b0;
    endtask

    task automatic ensure(input logic want_halted);
        int n;
        if (want_halted && !halted_m) begin
            iCORE_STOPPED = 1'b1;
            issue(4'hF, 12'h0, 32'h0);
            wait_valid(20, n);
            check("halt_err", 32'(oDEBUG_CMD_ERROR), 32'd0);
            tick();
            halted_m = 1'b1;
        end else if (!want_halted && halted_m) begin
            do_imm("go_pre", 4'h8, 12'h0, 1'b0, 1'b0, 1'b0);
            iCORE_STOPPED = 1'b0;
        end
    endtask

    initial begin
        int   n;
        logic seen;
        vecs[0]  = '{"rd_run",       1'b0, 4'h0, 12'd5,   1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"wr_run",       1'b0, 4'h1, 12'd5,   1'b1, 1'b0, 1'b0};
        vecs[2]  = '{"step_run",     1'b0, 4'hA, 12'd0,   1'b1, 1'b0, 1'b0};
        vecs[3]  = '{"undef3",       1'b0, 4'h3, 12'd0,   1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"undefE",       1'b0, 4'hE, 12'd0,   1'b1, 1'b0, 1'b0};
        vecs[5]  = '{"go_run",       1'b0, 4'h8, 12'd0,   1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"intgo_run",    1'b0, 4'h9, 12'd0,   1'b0, 1'b1, 1'b0};
        vecs[7]  = '{"rd_t38",       1'b1, 4'h0, 12'd38,  1'b1, 1'b0, 1'b1};
        vecs[8]  = '{"rd_t040",      1'b1, 4'h0, 12'h040, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{"stop_halted",  1'b1, 4'hF, 12'd0,   1'b0, 1'b0, 1'b1};
        vecs[10] = '{"undef5",       1'b1, 4'h5, 12'd0,   1'b1, 1'b0, 1'b1};
        vecs[11] = '{"intgo_halted", 1'b1, 4'h9, 12'd0,   1'b0, 1'b1, 1'b0};

        inRESET = 1'b0; iDEBUG_CMD_REQ = 1'b0; iDEBUG_CMD_COMMAND = 4'h0;
        iDEBUG_CMD_TARGET = 12'h0; iDEBUG_CMD_DATA = 32'h0; iCORE_STOPPED = 1'b0;
        iCORE_STEP_DONE = 1'b0; iREG_ACK = 1'b0; iREG_RDATA = 32'h0;
        tick(); tick();
        check("reset_ctrl", {24'h0, oDEBUG_CMD_BUSY, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR,
              oCORE_STOP_REQ, oCORE_STEP_REQ, oCORE_INTGO, oREG_REQ, oREG_RW}, 32'h0);
        check("reset_bus", oDEBUG_CMD_DATA | oREG_WDATA | {26'h0, oREG_ADDR}, 32'h0);
        inRESET = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            ensure(vecs[i].pre_halted);
            do_imm(vecs[i].name, vecs[i].cmd, vecs[i].tgt, vecs[i].exp_err,
                   vecs[i].exp_intgo, vecs[i].exp_stop);
        end

        // STOP while running; core reports stopped 3 cycles after STOP_REQ
        iCORE_STOPPED = 1'b0;
        issue(4'hF, 12'h0, 32'h0);
        check("s1_stopreq", 32'(oCORE_STOP_REQ), 32'd1);
        check("s1_wait", {30'h0, oDEBUG_CMD_BUSY, oDEBUG_CMD_VALID}, 32'h2);
        tick(); tick(); tick();
        check("s1_novalid", 32'(oDEBUG_CMD_VALID), 32'd0);
        iCORE_STOPPED = 1'b1;
        wait_valid(20, n);
        check("s1_lat", 32'(n), 32'd1);
        check("s1_err", 32'(oDEBUG_CMD_ERROR), 32'd0);
        check("s1_busy_v", 32'(oDEBUG_CMD_BUSY), 32'd1);
        tick();
        check("s1_after", {30'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_BUSY}, 32'h0);
        check("s1_hold", 32'(oCORE_STOP_REQ), 32'd1);
        halted_m = 1'b1;

        // Halted READ target 5, ACK after two cycles
        issue(4'h0, 12'd5, 32'h0);
        check("s2_req", {24'h0, oREG_REQ, oREG_RW, oREG_ADDR}, {24'h0, 2'b10, 6'd5});
        tick();
        check("s2_hold", {23'h0, oDEBUG_CMD_VALID, oREG_REQ, oREG_RW, oREG_ADDR}, {23'h0, 3'b010, 6'd5});
        tick();
        iREG_ACK = 1'b1; iREG_RDATA = 32'hDEADBEEF;
        tick();
        iREG_ACK = 1'b0; iREG_RDATA = 32'h0;
        check("s2_valid", {30'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR}, 32'h2);
        check("s2_data", oDEBUG_CMD_DATA, 32'hDEADBEEF);
        check("s2_reqdrop", 32'(oREG_REQ), 32'd0);
        tick();
        check("s2_after", {30'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_BUSY} | oDEBUG_CMD_DATA, 32'h0);

        // Halted WRITE target 34, second REQ while busy is ignored
        issue(4'h1, 12'd34, 32'h0000_1000);
        iDEBUG_CMD_REQ = 1'b1; iDEBUG_CMD_COMMAND = 4'h8;
        check("s4_rw", {24'h0, oREG_REQ, oREG_RW, oREG_ADDR}, {24'h0, 2'b11, 6'd34});
        check("s4_wdata", oREG_WDATA, 32'h0000_1000);
        tick();
        iDEBUG_CMD_REQ = 1'b0;
        check("s4_ignored", {29'h0, oCORE_STOP_REQ, oREG_REQ, oDEBUG_CMD_VALID}, 32'h6);
        iREG_ACK = 1'b1;
        tick();
        iREG_ACK = 1'b0;
        check("s4_valid", {30'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR}, 32'h2);
        check("s4_data", oDEBUG_CMD_DATA, 32'h0);
        tick();
        check("s4_after", {29'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_BUSY, oCORE_STOP_REQ}, 32'h1);
        tick();
        check("s4_noresp", 32'(oDEBUG_CMD_VALID), 32'd0);

        // SINGLESTEP with DONE two cycles after accept
        issue(4'hA, 12'h0, 32'h0);
        check("s5_step", 32'(oCORE_STEP_REQ), 32'd1);
        tick();
        check("s5_steppulse", 32'(oCORE_STEP_REQ), 32'd0);
        iCORE_STEP_DONE = 1'b1;
        tick();
        iCORE_STEP_DONE = 1'b0;
        check("s5_valid", {29'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR, oCORE_STOP_REQ}, 32'h5);
        tick();

        // SINGLESTEP without DONE: timeout after 8 wait cycles
        issue(4'hA, 12'h0, 32'h0);
        wait_valid(20, n);
        check("s5_to_lat", 32'(n), 32'd8);
        check("s5_to_err", {30'h0, oDEBUG_CMD_ERROR, oCORE_STOP_REQ}, 32'h3);
        tick();
        check("s5_to_after", 32'(oDEBUG_CMD_BUSY), 32'd0);

        // ACK on the timeout edge wins
        issue(4'h0, 12'd7, 32'h0);
        repeat (7) tick();
        check("race_novalid", 32'(oDEBUG_CMD_VALID), 32'd0);
        iREG_ACK = 1'b1; iREG_RDATA = 32'h1234_5678;
        tick();
        iREG_ACK = 1'b0; iREG_RDATA = 32'h0;
        check("race_ok", {30'h0, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR}, 32'h2);
        check("race_data", oDEBUG_CMD_DATA, 32'h1234_5678);
        tick();

        // STOP timeout releases the core and leaves it running
        ensure(1'b0);
        issue(4'hF, 12'h0, 32'h0);
        wait_valid(20, n);
        check("stop_to_lat", 32'(n), 32'd8);
        check("stop_to_err", {30'h0, oDEBUG_CMD_ERROR, oCORE_STOP_REQ}, 32'h2);
        tick();
        do_imm("rd_after_to", 4'h0, 12'd5, 1'b1, 1'b0, 1'b0);

        // Reset during REG_WAIT drops the command silently
        ensure(1'b1);
        issue(4'h0, 12'd1, 32'h0);
        check("s6_req", 32'(oREG_REQ), 32'd1);
        inRESET = 1'b0;
        tick();
        check("s6_rst_ctrl", {24'h0, oDEBUG_CMD_BUSY, oDEBUG_CMD_VALID, oDEBUG_CMD_ERROR,
              oCORE_STOP_REQ, oCORE_STEP_REQ, oCORE_INTGO, oREG_REQ, oREG_RW}, 32'h0);
        check("s6_rst_bus", oDEBUG_CMD_DATA | oREG_WDATA | {26'h0, oREG_ADDR}, 32'h0);
        inRESET = 1'b1;
        halted_m = 1'b0;
        iREG_ACK = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | oDEBUG_CMD_VALID | oREG_REQ;
        end
        iREG_ACK = 1'b0;
        check("s6_novalid", 32'(seen), 32'd0);
        do_imm("s6_undef3", 4'h3, 12'h0, 1'b1, 1'b0, 1'b0);
        do_imm("s6_intgo", 4'h9, 12'h0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=hang required=finish");
        $fatal(1);
    end

endmodule
